// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package dmem_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with byte-lane write enables and a registered read port.
// Contents are deliberately never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned IDX_W       = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < int'(BE_W); i++) begin
          if (be[i]) begin
            mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: valid/ready request, fixed latency, one-cycle response.
// Define DMEM_ERR_EN to reject misaligned and out-of-range requests with resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam bit          ZeroWait = (WAIT_CYCLES == 0);
  localparam logic [WAIT_CNT_W-1:0] CntInit =
      ZeroWait ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 32'd1);

  dmem_state_t state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic accept;

  logic              lat_write_q;
  logic [WORD_W-1:0] lat_addr_q;
  logic [WORD_W-1:0] lat_wdata_q;
  logic [BE_W-1:0]   lat_be_q;

  logic err_q;
  logic rd_ok_q;

  logic              acc_write;
  logic [WORD_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_err;
  logic              access;
  logic [WORD_W-1:0] arr_rdata;

  // With zero latency the access happens on the accepting edge, so use the live request.
  always_comb begin
    acc_write = lat_write_q;
    acc_addr  = lat_addr_q;
    acc_wdata = lat_wdata_q;
    acc_be    = lat_be_q;
    if (state_q == StIdle) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

`ifdef DMEM_ERR_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || (|acc_addr[WORD_W-1:IdxW+2]);
`else
  logic unused_addr;
  assign acc_err     = 1'b0;
  assign unused_addr = ^{acc_addr[WORD_W-1:IdxW+2], acc_addr[1:0]};
`endif

  assign access = !rst &&
                  ((ZeroWait && (state_q == StIdle) && req_valid) ||
                   ((state_q == StWait) && (cnt_q == '0)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (ZeroWait) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      err_q       <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_write_q <= req_write;
        lat_addr_q  <= req_addr;
        lat_wdata_q <= req_wdata;
        lat_be_q    <= req_be;
      end
      if (access) begin
        err_q   <= acc_err;
        rd_ok_q <= !acc_write && !acc_err;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IdxW)
  ) u_array (
    .clk  (clk),
    .en   (access && !acc_err),
    .we   (acc_write),
    .be   (acc_be),
    .idx  (acc_addr[IdxW+1:2]),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  // Array read register only changes on loads; rd_ok_q masks it to zero for stores/errors.
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rd_ok_q ? arr_rdata : '0;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 has two wait cycles, instance 1 has none.
// A transaction-level model predicts ready/valid/data every cycle.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        rv [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [31:0] rwd[2];
  logic [3:0]  rbe[2];
  logic        rdy[2];
  logic        vld[2];
  logic [31:0] rd [2];
  logic        er [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(rwd[0]), .req_be(rbe[0]), .req_ready(rdy[0]), .resp_valid(vld[0]),
    .resp_rdata(rd[0]), .resp_err(er[0])
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(rwd[1]), .req_be(rbe[1]), .req_ready(rdy[1]), .resp_valid(vld[1]),
    .resp_rdata(rd[1]), .resp_err(er[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, need 0x%08h", name, act, exp);
  endtask

  function automatic int wcyc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Model: a request accepted at edge k occupies the responder for cycles k..k+W,
  // commits at edge k+W and pulses resp_valid in cycle k+W.
  int          cyc = 0;
  int          busy_end[2] = '{-1, -1};
  int          resp_at [2] = '{-1, -1};
  int          acc_cnt [2] = '{0, 0};
  logic [31:0] mmem[2][64];
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
  logic        exp_err[2] = '{1'b0, 1'b0};
  bit          pv   [2] = '{1'b0, 1'b0};
  int          pedge[2];
  logic        pw   [2];
  logic [31:0] pa   [2];
  logic [31:0] pd   [2];
  logic [3:0]  pb   [2];
  logic        m_e;
  int          m_idx;

  initial begin
    for (int i = 0; i < 2; i++) for (int j = 0; j < 64; j++) mmem[i][j] = 32'h0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        pv[i] = 1'b0; busy_end[i] = -1; resp_at[i] = -1;
        exp_rd[i] = 32'h0; exp_err[i] = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if ((cyc - 1 > busy_end[i]) && rv[i]) begin
          acc_cnt[i]++;
          busy_end[i] = cyc + wcyc(i);
          pv[i] = 1'b1; pedge[i] = cyc + wcyc(i);
          pw[i] = rw[i]; pa[i] = ra[i]; pd[i] = rwd[i]; pb[i] = rbe[i];
        end
        if (pv[i] && pedge[i] == cyc) begin
          pv[i] = 1'b0;
          resp_at[i] = cyc;
`ifdef DMEM_ERR_EN
          m_e = (pa[i] % 4 != 0) || (pa[i] >= 32'd256);
`else
          m_e = 1'b0;
`endif
          m_idx = int'((pa[i] / 4) % 64);
          exp_err[i] = m_e;
          exp_rd[i] = 32'h0;
          if (!m_e) begin
            if (pw[i]) begin
              for (int b = 0; b < 4; b++)
                if (pb[i][b]) mmem[i][m_idx][8*b +: 8] = pd[i][8*b +: 8];
            end else begin
              exp_rd[i] = mmem[i][m_idx];
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready[%0d] cyc %0d", i, cyc), {31'b0, rdy[i]},
            {31'b0, (cyc > busy_end[i])});
        chk($sformatf("valid[%0d] cyc %0d", i, cyc), {31'b0, vld[i]},
            {31'b0, (resp_at[i] == cyc)});
        chk($sformatf("rdata[%0d] cyc %0d", i, cyc), rd[i], exp_rd[i]);
        chk($sformatf("err[%0d] cyc %0d", i, cyc), {31'b0, er[i]}, {31'b0, exp_err[i]});
      end
    end
  end

  task automatic do_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    int t;
    @(negedge clk);
    rv[i] = 1'b1; rw[i] = w; ra[i] = a; rwd[i] = d; rbe[i] = be;
    t = 0;
    while (!rdy[i] && t < 50) begin
      @(negedge clk);
      t++;
    end
    rdata = 32'h0; err = 1'b0; lat = -1;
    if (!rdy[i]) begin
      chk("accept timeout", 32'd0, 32'd1);
      rv[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 rv[i] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!vld[i] && lat < 50);
    if (!vld[i]) chk("response timeout", 32'd0, 32'd1);
    rdata = rd[i];
    err = er[i];
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, n, c, p0, a0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 32'h0; rwd[i] = 32'h0; rbe[i] = 4'h0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset ready", {31'b0, rdy[i]}, 32'd1);
      chk("reset valid", {31'b0, vld[i]}, 32'd0);
      chk("reset rdata", rd[i], 32'h0);
      chk("reset err", {31'b0, er[i]}, 32'd0);
    end
    #2 rst = 1'b0;

    // Basic store/load with two wait cycles
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, lat);
    chk("store latency", lat, 32'd3);
    chk("store rdata", d, 32'h0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
    chk("load 0x10", d, 32'hDEADBEEF);
    chk("load latency", lat, 32'd3);

    // Byte lanes
    do_req(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, d, e, lat);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, d, e, lat);
    chk("lane0 load", d, 32'hDEADBEAA);
    do_req(0, 1'b1, 32'h10, 32'h11223344, 4'h0, d, e, lat);
    chk("be0 store err", {31'b0, e}, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, d, e, lat);
    chk("be0 load", d, 32'hDEADBEAA);

    // Reset one cycle into WAIT discards the store
    do_req(0, 1'b1, 32'h18, 32'h12345678, 4'hF, d, e, lat);
    p0 = 0;
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h18; rwd[0] = 32'h1; rbe[0] = 4'hF;
    @(posedge clk);
    #1 rv[0] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst ready", {31'b0, rdy[0]}, 32'd1);
    chk("rst valid", {31'b0, vld[0]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (vld[0]) p0++;
    end
    chk("no pulse after reset", p0, 32'd0);
    do_req(0, 1'b0, 32'h18, 32'h0, 4'hF, d, e, lat);
    chk("discarded store", d, 32'h12345678);

    // Zero latency, back-to-back with req_valid held high
    do_req(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, d, e, lat);
    chk("w0 latency", lat, 32'd1);
    @(negedge clk);
    a0 = acc_cnt[1];
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h20; rbe[1] = 4'hF;
    n = 0; c = 0;
    while (n < 4 && c < 30) begin
      @(negedge clk);
      c++;
      if (vld[1]) begin
        n++;
        chk("b2b rdata", rd[1], 32'hCAFEF00D);
      end
    end
    rv[1] = 1'b0;
    chk("b2b pulses", n, 32'd4);
    chk("b2b cycles", c, 32'd7);
    chk("b2b accepts", acc_cnt[1] - a0, 32'd4);
    repeat (4) @(negedge clk);

    // Address handling with and without error checking
    do_req(0, 1'b1, 32'h0, 32'h0, 4'hF, d, e, lat);
    do_req(0, 1'b0, 32'h13, 32'h0, 4'hF, d, e, lat);
`ifdef DMEM_ERR_EN
    chk("misaligned err", {31'b0, e}, 32'd1);
    chk("misaligned rdata", d, 32'h0);
`else
    chk("misaligned err", {31'b0, e}, 32'd0);
    chk("misaligned rdata", d, 32'hDEADBEAA);
`endif
    do_req(0, 1'b1, 32'h100, 32'h55, 4'hF, d, e, lat);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'hF, d, e, lat);
`ifdef DMEM_ERR_EN
    chk("range load 0x0", d, 32'h0);
`else
    chk("wrap load 0x0", d, 32'h55);
`endif
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, d, e, lat);
    chk("0x10 untouched", d, 32'hDEADBEAA);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need $finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS R2000 pipeline: the memory-side end of the MEM-stage load/store interface, replacing the bench's behavioural RAM array. It accepts one word request at a time over a valid/ready handshake. It models a configurable access latency, commits byte-masked stores and returns load data with a single-cycle response pulse. While busy it deasserts `req_ready`, which the MEM stage uses as its stall source.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words stored; power of two, ≥ 4.
- `WAIT_CYCLES`, default 2: extra latency cycles between accept and response; range 0–15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  MEM stage presents a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables; bit i enables bits 8i+7:8i.
- `req_ready`  out  1  responder can accept a request this cycle.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  request was rejected (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - `req_ready`=1.
  - On an edge with `req_valid`=1, the request is accepted and write, addr, wdata and be are latched.
  - If `WAIT_CYCLES`=0, go to RESP and perform the access on that edge.
  - Otherwise, go to WAIT with counter = `WAIT_CYCLES`−1.
- WAIT
  - `req_ready`=0.
  - If counter ≠ 0, decrement.
  - If counter = 0, go to RESP and perform the access on that edge.
- Access
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Store: write only the enabled byte lanes; `resp_rdata` is registered as 0.
  - Load: the full word is registered into `resp_rdata`; `req_be` is ignored.
  - `req_be`=0 on a store: no lanes change, response is still issued, no error.
- RESP
  - `resp_valid`=1 and `req_ready`=0 for exactly one cycle, then go to IDLE.
  - `resp_rdata`/`resp_err` hold their values until the next access.
- Inputs outside an accepting IDLE edge are ignored; `req_valid` may stay high, and the request is accepted again when the FSM next returns to IDLE.
- Reset (including mid-WAIT)
  - FSM returns to IDLE.
  - Outputs: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0.
  - A store not yet committed is discarded.
  - Array contents are not reset.
  - Release of `rst` is taken synchronously by the first following edge.

## Timing
- Request accepted at edge e0 → `resp_valid` is high in the cycle after edge e0+`WAIT_CYCLES`, i.e. latency is `WAIT_CYCLES`+1 cycles.
- `req_ready` returns high in the cycle after edge e0+`WAIT_CYCLES`+1.
- Maximum throughput is one request per `WAIT_CYCLES`+2 cycles.
- All outputs are registered; there is no combinational path from request inputs to any output.
- The store is visible to a load accepted at any later edge.

## Configuration
- `DMEM_ERR_EN` defined
  - Misaligned (addr[1:0]≠0) or out-of-range (addr ≥ 4·`DEPTH_WORDS`) requests complete with normal timing and `resp_err`=1.
  - No array write occurs, and `resp_rdata`=0.
- `DMEM_ERR_EN` undefined
  - `resp_err` is tied to 0.
  - addr[1:0] and upper address bits are ignored, so the address wraps modulo `DEPTH_WORDS`.
  - The access always proceeds.

## Structure
- Shared package `dmem_pkg`:
  - `WORD_W`=32 and `BE_W`=4;
  - the `dmem_state_t` enum (IDLE, WAIT, RESP);
  - the `WAIT_CNT_W`=4 counter width constant.
- Sub-module `dmem_array`: synchronous single-port storage with byte-lane write enables and a registered read port, instantiated once. The FSM, counter, request latch and error check live in `dmem_responder`.

## Test plan
- Reset mid-WAIT: store 0x1 to 0x18, assert `rst` one cycle into WAIT → `resp_valid` never pulses, `req_ready`=1 immediately; a subsequent load from 0x18 returns the prior contents.
- Basic store/load, `WAIT_CYCLES`=2: store 0xDEADBEEF, be=0xF, addr 0x10 → `resp_valid` in the 3rd cycle after accept, `req_ready` low for 3 cycles; load 0x10 → `resp_rdata`=0xDEADBEEF.
- Byte lanes: after the above, store 0x000000AA with be=0x1 to 0x10 → a load returns 0xDEADBEAA; store with be=0x0 → a load still returns 0xDEADBEAA, `resp_err`=0.
- Zero latency, back-to-back: `WAIT_CYCLES`=0, `req_valid` held high for 4 loads → responses on every 2nd cycle, each request accepted exactly once.
- Errors with `DMEM_ERR_EN`: load at 0x13 → `resp_err`=1, `resp_rdata`=0; store at 0x100 with `DEPTH_WORDS`=64 → `resp_err`=1 and no word changes. Without the macro: store 0x55 to 0x100 → a load at 0x0 returns 0x55.
